// File: rtl/redstone_symbol_tx.sv
// redstone_symbol_tx
// Transmit end of the redstone analog link. A WIDTH-bit word is sent as a
// timed frame of 4-bit signal strengths: a start symbol (15), then WIDTH/4
// data nibbles MSB-first. Each symbol is held HOLD ticks and then followed by
// GAP ticks of strength 0, so the receiver's 2-tick debounce sees every
// symbol as a separate event.
//
// Build option: define REDSTONE_CHECKSUM_EN to append one extra symbol that
// carries the mod-16 sum of the data nibbles.
//
// Ports
//   clk       : clock, one cycle per redstone tick
//   reset     : synchronous, active-high
//   in_valid  : in_data is offered
//   in_ready  : transmitter is idle and takes a word this cycle
//   in_data   : WIDTH-bit word, latched on accept
//   line      : strength driven onto the link
//   busy      : a frame is in progress
//   done      : one-cycle pulse at frame completion
//
// State | meaning
// IDLE  | line=0, waiting for a word
// START | line=15 for HOLD ticks
// SYM   | line=current nibble (or checksum) for HOLD ticks
// GAP   | line=0 for GAP ticks, then next symbol or IDLE

module redstone_symbol_tx #(
  parameter int WIDTH = 12,
  parameter int HOLD  = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       line,
  output logic             busy,
  output logic             done
);

  localparam int NIB  = WIDTH / 4;
`ifdef REDSTONE_CHECKSUM_EN
  localparam int NSYM = NIB + 1;
`else
  localparam int NSYM = NIB;
`endif
  localparam int TMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int TW   = $clog2(TMAX);
  localparam int CW   = $clog2(NSYM + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_SYM, S_GAP} state_t;

  state_t           r_state;
  logic [TW-1:0]    r_tick;
  logic [CW-1:0]    r_sym_cnt;   // symbols after START that have finished their hold
  logic [WIDTH-1:0] r_shift;
  logic [3:0]       r_line;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
`ifdef REDSTONE_CHECKSUM_EN
  logic [3:0]       r_csum;
`endif

  logic [WIDTH-1:0] w_shift_next;
  logic [3:0]       w_nib_next;
  logic             w_hold_end;
  logic             w_gap_end;

  assign w_shift_next = r_shift << 4;
  // The first data symbol follows START directly, so it uses the unshifted word.
  assign w_nib_next   = (r_sym_cnt == '0) ? r_shift[WIDTH-1 -: 4] : w_shift_next[WIDTH-1 -: 4];
  assign w_hold_end   = (r_tick == TW'(HOLD - 1));
  assign w_gap_end    = (r_tick == TW'(GAP - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tick    <= '0;
      r_sym_cnt <= '0;
      r_shift   <= '0;
      r_line    <= 4'd0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef REDSTONE_CHECKSUM_EN
      r_csum    <= 4'd0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_ready) begin
            r_shift   <= in_data;
            r_tick    <= '0;
            r_sym_cnt <= '0;
            r_state   <= S_START;
            r_line    <= 4'd15;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
`ifdef REDSTONE_CHECKSUM_EN
            r_csum    <= 4'd0;
`endif
          end
        end
        S_START, S_SYM: begin
          if (w_hold_end) begin
            r_state <= S_GAP;
            r_tick  <= '0;
            r_line  <= 4'd0;
            if (r_state == S_SYM) r_sym_cnt <= r_sym_cnt + CW'(1);
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        S_GAP: begin
          if (w_gap_end) begin
            r_tick <= '0;
            if (r_sym_cnt == CW'(NSYM)) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
`ifdef REDSTONE_CHECKSUM_EN
            end else if (r_sym_cnt == CW'(NIB)) begin
              r_state <= S_SYM;
              r_line  <= r_csum;
`endif
            end else begin
              r_state <= S_SYM;
              r_line  <= w_nib_next;
              if (r_sym_cnt != '0) r_shift <= w_shift_next;
`ifdef REDSTONE_CHECKSUM_EN
              r_csum  <= r_csum + w_nib_next;
`endif
            end
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign line     = r_line;
  assign in_ready = r_ready;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_redstone_symbol_tx.sv
module tb_redstone_symbol_tx;

  localparam int WIDTH = 12;
  localparam int HOLD  = 4;
  localparam int GAP   = 1;
  localparam int NIB   = WIDTH / 4;
`ifdef REDSTONE_CHECKSUM_EN
  localparam int NSYM  = NIB + 1;
`else
  localparam int NSYM  = NIB;
`endif
  localparam int PER   = HOLD + GAP;
  localparam int FRAME = (1 + NSYM) * PER;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready, busy, done;
  logic [3:0]       line;

  logic             c_valid = 1'b0;
  logic [3:0]       c_data = 4'd0;
  logic             c_ready, c_busy, c_done;
  logic [3:0]       c_line;

  redstone_symbol_tx #(.WIDTH(WIDTH), .HOLD(HOLD), .GAP(GAP)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .line(line), .busy(busy), .done(done)
  );

  redstone_symbol_tx #(.WIDTH(4), .HOLD(3), .GAP(2)) u_dut_c (
    .clk(clk), .reset(reset), .in_valid(c_valid), .in_ready(c_ready),
    .in_data(c_data), .line(c_line), .busy(c_busy), .done(c_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Scoreboard: expected per-cycle line values and expected words.
  int               exp_line[$];
  logic [WIDTH-1:0] exp_word[$];
  int  m_left  = 0;
  bit  m_ready = 1'b1;
  bit  m_done  = 1'b0;
  bit  m_acc   = 1'b0;
  bit  m_rst   = 1'b0;
  bit  mon_en  = 1'b0;

  task automatic push_frame(input logic [WIDTH-1:0] w);
    logic [3:0] sum;
    logic [3:0] nib;
    sum = 4'd0;
    for (int k = 0; k < HOLD; k++) exp_line.push_back(15);
    for (int k = 0; k < GAP; k++)  exp_line.push_back(0);
    for (int i = NIB - 1; i >= 0; i--) begin
      nib = w[4*i +: 4];
      sum = sum + nib;
      for (int k = 0; k < HOLD; k++) exp_line.push_back(int'(nib));
      for (int k = 0; k < GAP; k++)  exp_line.push_back(0);
    end
`ifdef REDSTONE_CHECKSUM_EN
    for (int k = 0; k < HOLD; k++) exp_line.push_back(int'(sum));
    for (int k = 0; k < GAP; k++)  exp_line.push_back(0);
`endif
    exp_word.push_back(w);
  endtask

  always @(posedge clk) begin
    m_acc  = 1'b0;
    m_done = 1'b0;
    m_rst  = 1'b0;
    if (reset) begin
      m_left  = 0;
      m_ready = 1'b1;
      m_rst   = 1'b1;
      exp_line.delete();
      exp_word.delete();
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done  = 1'b1;
        m_ready = 1'b1;
      end
    end else if (in_valid) begin
      push_frame(in_data);
      m_left  = FRAME;
      m_ready = 1'b0;
      m_acc   = 1'b1;
    end
  end

  // Monitor plus a timing-sliced debounce receiver on the line.
  bit               rx_act = 1'b0;
  int               rx_t   = 0;
  int               rx_a   = 0;
  int               rx_prev = 0;
  logic [WIDTH-1:0] rx_word;
  logic [3:0]       rx_sum;

  always @(negedge clk) begin
    int exp_l;
    int slot, off;
    if (mon_en) begin
      chk("busy", busy, (m_left != 0) ? 1 : 0);
      chk("in_ready", in_ready, m_ready);
      chk("done", done, m_done);
      exp_l = 0;
      if (m_left != 0) begin
        if (exp_line.size() == 0) chk("line_queue_empty", 1, 0);
        else exp_l = exp_line.pop_front();
      end
      chk("line", line, exp_l);

      if (m_rst) begin
        rx_act = 1'b0;
      end else if (!rx_act) begin
        if (line == 4'd15 && rx_prev == 0) begin
          rx_act  = 1'b1;
          rx_t    = 0;
          rx_word = '0;
          rx_sum  = 4'd0;
        end
      end else begin
        rx_t++;
        slot = rx_t / PER;
        off  = rx_t % PER;
        if (off >= HOLD) chk("rx_gap", line, 0);
        if (off == 1) rx_a = int'(line);
        if (off == 2) begin
          chk("rx_split", line, rx_a);
          if (slot == 0) chk("rx_start", line, 15);
          else if (slot <= NIB) begin
            rx_word = {rx_word[WIDTH-5:0], line};
            rx_sum  = rx_sum + line;
          end else chk("rx_csum", line, rx_sum);
        end
        if (rx_t == FRAME - 1) begin
          rx_act = 1'b0;
          if (exp_word.size() == 0) chk("rx_word_queue_empty", 1, 0);
          else chk("rx_word", rx_word, exp_word.pop_front());
        end
      end
      rx_prev = int'(line);
    end
  end

  task automatic send(input logic [WIDTH-1:0] w);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(posedge clk);
      #1;
      if (m_acc) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) chk("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
  endtask

  // Called at the negedge of cycle 1 after accept.
  task automatic wait_done(input string tag);
    int cyc;
    cyc = 1;
    while (!done && cyc < FRAME + 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_cycle"}, cyc, FRAME + 1);
    chk({tag, "_ready_at_done"}, in_ready, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4 * FRAME && m_left != 0; i++) @(negedge clk);
    chk("idle_timeout", (m_left == 0) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int acc_cnt;
    int c_exp[$];
    int cf;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    chk("rst_line", line, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    send(12'hA05);
    wait_done("basic");
    wait_idle();

    send(12'hFFF);
    wait_done("fff");
    wait_idle();

    // Continuous in_valid with alternating words; data changes right after each accept.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 12'h123;
    acc_cnt  = 0;
    for (int i = 0; i < 6 * (FRAME + 2) && acc_cnt < 4; i++) begin
      @(posedge clk);
      #1;
      if (m_acc) begin
        acc_cnt++;
        @(negedge clk);
        in_data = (acc_cnt % 2 == 1) ? 12'h456 : 12'h123;
        if (acc_cnt == 4) in_valid = 1'b0;
      end
    end
    chk("hand_accepts", acc_cnt, 4);
    in_valid = 1'b0;
    wait_idle();

    // Reset lands on cycle 7 of a frame.
    send(12'h3C7);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_line", line, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    send(12'h9C3);
    wait_done("after_abort");
    wait_idle();

    for (int n = 0; n < 100; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(WIDTH'($urandom));
    end
    wait_idle();

    // WIDTH=4, HOLD=3, GAP=2 corner on the second instance.
    for (int k = 0; k < 3; k++) c_exp.push_back(15);
    for (int k = 0; k < 2; k++) c_exp.push_back(0);
    for (int k = 0; k < 3; k++) c_exp.push_back(0);
    for (int k = 0; k < 2; k++) c_exp.push_back(0);
`ifdef REDSTONE_CHECKSUM_EN
    for (int k = 0; k < 5; k++) c_exp.push_back(0);
`endif
    cf = c_exp.size();
    chk("c_idle_ready", c_ready, 1);
    c_valid = 1'b1;
    c_data  = 4'h0;
    @(negedge clk);
    c_valid = 1'b0;
    c_data  = 4'hF;
    for (int i = 0; i < cf; i++) begin
      chk("c_line", c_line, c_exp[i]);
      chk("c_busy", c_busy, 1);
      chk("c_done_early", c_done, 0);
      @(negedge clk);
    end
    chk("c_done", c_done, 1);
    chk("c_ready_at_done", c_ready, 1);
    chk("c_line_idle", c_line, 0);
    @(negedge clk);
    chk("c_done_single", c_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
